dmem_arbiter: RTL and testbench

Single-port arbiter and burst sequencer sharing the data memory between the pipeline MEM stage (port 0) and a block-transfer requester (port 1), e.g. a test loader or result dumper. Port 0 gets zero-latency access and wins every cycle unless port 1 has been starved for `MAX_WAIT` consecutive grants. Port 1 issues multi-beat word bursts that the arbiter address-sequences internally. The arbiter sits between the pipeline and the `data_memory` instance, driving its `mem_read`, `mem_write`, `adr` and `write_data` inputs.

---
 rtl/dmem_arbiter_if.sv | 50 +++++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM stage, the block-transfer requester, the arbiter and data memory.
interface dmem_arbiter_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned BURST_W = 4
);
  logic               p0_read;
  logic               p0_write;
  logic [WIDTH-1:0]   p0_adr;
  logic [WIDTH-1:0]   p0_wdata;
  logic               p0_gnt;
  logic               p0_stall;
  logic [WIDTH-1:0]   p0_rdata;

  logic               p1_req;
  logic               p1_we;
  logic [WIDTH-1:0]   p1_adr;
  logic [BURST_W-1:0] p1_len;
  logic [WIDTH-1:0]   p1_wdata;
  logic               p1_wready;
  logic               p1_rvalid;
  logic [WIDTH-1:0]   p1_rdata;
  logic               p1_busy;
  logic               p1_done;

  logic               mem_read;
  logic               mem_write;
  logic [WIDTH-1:0]   mem_adr;
  logic [WIDTH-1:0]   mem_wdata;
  logic [WIDTH-1:0]   mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_read, p0_write, p0_adr, p0_wdata,
    output p0_gnt, p0_stall, p0_rdata,
    input  p1_req, p1_we, p1_adr, p1_len, p1_wdata,
    output p1_wready, p1_rvalid, p1_rdata, p1_busy, p1_done,
    output mem_read, mem_write, mem_adr, mem_wdata,
    input  mem_rdata
  );

  // Requester / memory side
  modport master (
    output p0_read, p0_write, p0_adr, p0_wdata,
    input  p0_gnt, p0_stall, p0_rdata,
    output p1_req, p1_we, p1_adr, p1_len, p1_wdata,
    input  p1_wready, p1_rvalid, p1_rdata, p1_busy, p1_done,
    input  mem_read, mem_write, mem_adr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: zero-latency MEM-stage port plus an internally sequenced burst port
// with a bounded starvation window for the burst side.
module dmem_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned BURST_W  = 4,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);
  localparam int unsigned WAIT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam int unsigned REM_W  = BURST_W + 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  logic [0:0]       state, state_nx;
  logic [WIDTH-1:0] cur_adr, cur_adr_nx;
  logic [REM_W-1:0] remaining, remaining_nx;
  logic             dir, dir_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic             done_r, done_nx;

  logic p0_req, in_burst, p0_win, beat, accept, last_beat;

  // Arbitration and next-state
  always_comb begin
    state_nx     = state;
    cur_adr_nx   = cur_adr;
    remaining_nx = remaining;
    dir_nx       = dir;
    wait_nx      = wait_cnt;
    done_nx      = 1'b0;

    p0_req    = bus.p0_read | bus.p0_write;
    in_burst  = (state == BURST);
    p0_win    = p0_req & (~in_burst | (wait_cnt < WAIT_MAX));
    beat      = in_burst & ~p0_win;
    accept    = ~in_burst & bus.p1_req & ~done_r;
    last_beat = beat & (remaining == REM_W'(1));

    if (accept) begin
      state_nx     = BURST;
      cur_adr_nx   = {bus.p1_adr[WIDTH-1:2], 2'b00};
      remaining_nx = (bus.p1_len == '0) ? REM_W'(1) : {1'b0, bus.p1_len};
      dir_nx       = bus.p1_we;
      wait_nx      = '0;
    end else if (beat) begin
      cur_adr_nx   = cur_adr + WIDTH'(4);
      remaining_nx = remaining - REM_W'(1);
      wait_nx      = '0;
      if (last_beat) begin
        state_nx = IDLE;
        done_nx  = 1'b1;
      end
    end else if (in_burst && p0_win) begin
      wait_nx = wait_cnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cur_adr   <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      wait_cnt  <= '0;
      done_r    <= 1'b0;
    end else begin
      state     <= state_nx;
      cur_adr   <= cur_adr_nx;
      remaining <= remaining_nx;
      dir       <= dir_nx;
      wait_cnt  <= wait_nx;
      done_r    <= done_nx;
    end
  end

  // Memory-side mux; strobes and read data are held low while reset is asserted
  always_comb begin
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_adr   = '0;
    bus.mem_wdata = '0;
    if (rst) begin
      if (p0_win) begin
        bus.mem_read  = bus.p0_read & ~bus.p0_write;
        bus.mem_write = bus.p0_write;
        bus.mem_adr   = bus.p0_adr;
        bus.mem_wdata = bus.p0_wdata;
      end else if (beat) begin
        bus.mem_read  = ~dir;
        bus.mem_write = dir;
        bus.mem_adr   = cur_adr;
        bus.mem_wdata = bus.p1_wdata;
      end
    end
  end

  assign bus.p0_gnt    = p0_win;
  assign bus.p0_stall  = p0_req & ~p0_win;
  assign bus.p0_rdata  = rst ? bus.mem_rdata : '0;
  assign bus.p1_rdata  = rst ? bus.mem_rdata : '0;
  assign bus.p1_wready = beat & dir;
  assign bus.p1_rvalid = beat & ~dir;
  assign bus.p1_busy   = in_burst;
  assign bus.p1_done   = done_r;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small word-addressed memory model.
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  logic [31:0] mem [0:255];

  always #5 clk = ~clk;

  dmem_arbiter_if #(.WIDTH(32), .BURST_W(4)) bus ();

  dmem_arbiter #(.WIDTH(32), .BURST_W(4), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_rdata = mem[bus.mem_adr[9:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_adr[9:2]] <= bus.mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'hFF] = 32'hA5A5_A5A5;
    mem[8'h00] = 32'h5A5A_5A5A;
    rst = 1'b0;
    bus.p0_read = 1'b0; bus.p0_write = 1'b0; bus.p0_adr = '0; bus.p0_wdata = '0;
    bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_adr = '0; bus.p1_len = '0; bus.p1_wdata = '0;

    // Reset state
    @(negedge clk);
    check1("rst_busy", bus.p1_busy, 1'b0);
    check1("rst_done", bus.p1_done, 1'b0);
    check1("rst_gnt_idle", bus.p0_gnt, 1'b0);
    bus.p0_read = 1'b1;
    #1;
    check1("rst_p0_gnt_live", bus.p0_gnt, 1'b1);
    check1("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_p0_rdata", bus.p0_rdata, 32'h0);
    bus.p0_read = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();

    // Port 0 only: store then load
    bus.p0_write = 1'b1; bus.p0_adr = 32'h10; bus.p0_wdata = 32'hDEAD;
    @(negedge clk);
    check1("p0w_gnt", bus.p0_gnt, 1'b1);
    check1("p0w_stall", bus.p0_stall, 1'b0);
    check1("p0w_mem_write", bus.mem_write, 1'b1);
    check("p0w_mem_adr", bus.mem_adr, 32'h10);
    cyc();
    bus.p0_write = 1'b0; bus.p0_read = 1'b1;
    @(negedge clk);
    check1("p0r_gnt", bus.p0_gnt, 1'b1);
    check1("p0r_stall", bus.p0_stall, 1'b0);
    check1("p0r_mem_read", bus.mem_read, 1'b1);
    check("p0r_rdata", bus.p0_rdata, 32'hDEAD);
    cyc();
    bus.p0_read = 1'b0;

    // Uncontended write burst, base 0x103 aligned to 0x100, three beats
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_adr = 32'h103; bus.p1_len = 4'd3;
    @(negedge clk);
    check1("wb_accept_busy", bus.p1_busy, 1'b0);
    check1("wb_accept_nobeat", bus.mem_write, 1'b0);
    cyc();
    bus.p1_req = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      bus.p1_wdata = 32'(k);
      @(negedge clk);
      check1("wb_busy", bus.p1_busy, 1'b1);
      check1("wb_wready", bus.p1_wready, 1'b1);
      check1("wb_mem_write", bus.mem_write, 1'b1);
      check("wb_mem_adr", bus.mem_adr, 32'h100 + 32'(4 * (k - 1)));
      check("wb_mem_wdata", bus.mem_wdata, 32'(k));
      cyc();
    end
    @(negedge clk);
    check1("wb_done", bus.p1_done, 1'b1);
    check1("wb_done_busy", bus.p1_busy, 1'b0);
    check1("wb_done_nowrite", bus.mem_write, 1'b0);
    check("wb_mem_100", mem[8'h40], 32'd1);
    check("wb_mem_104", mem[8'h41], 32'd2);
    check("wb_mem_108", mem[8'h42], 32'd3);
    cyc();
    check1("wb_done_pulse", bus.p1_done, 1'b0);

    // Contended read burst: port 0 reads 0x10 continuously, port 1 reads 0x100/0x104
    bus.p0_read = 1'b1; bus.p0_adr = 32'h10;
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_adr = 32'h100; bus.p1_len = 4'd2;
    @(negedge clk);
    check1("cr_accept_p0_gnt", bus.p0_gnt, 1'b1);
    cyc();
    bus.p1_req = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k == 5 || k == 10) begin
        check1("cr_beat_stall", bus.p0_stall, 1'b1);
        check1("cr_beat_rvalid", bus.p1_rvalid, 1'b1);
        check("cr_beat_adr", bus.mem_adr, (k == 5) ? 32'h100 : 32'h104);
        check("cr_beat_rdata", bus.p1_rdata, (k == 5) ? 32'd1 : 32'd2);
      end else begin
        check1("cr_p0_gnt", bus.p0_gnt, 1'b1);
        check1("cr_no_rvalid", bus.p1_rvalid, 1'b0);
        check("cr_p0_rdata", bus.p0_rdata, 32'hDEAD);
        check1("cr_done", bus.p1_done, k == 11);
      end
      cyc();
    end
    bus.p0_read = 1'b0;

    // p1_len = 0 gives exactly one beat
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_adr = 32'h20; bus.p1_len = 4'd0;
    bus.p1_wdata = 32'h55;
    cyc();
    bus.p1_req = 1'b0;
    @(negedge clk);
    check1("l0_wready", bus.p1_wready, 1'b1);
    check("l0_adr", bus.mem_adr, 32'h20);
    cyc();
    @(negedge clk);
    check1("l0_done", bus.p1_done, 1'b1);
    check1("l0_no_second_beat", bus.mem_write, 1'b0);
    check("l0_mem", mem[8'h08], 32'h55);
    cyc();

    // Address wrap from 0xFFFFFFFC
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_adr = 32'hFFFF_FFFC; bus.p1_len = 4'd2;
    cyc();
    bus.p1_req = 1'b0;
    @(negedge clk);
    check("wr_adr0", bus.mem_adr, 32'hFFFF_FFFC);
    check("wr_rdata0", bus.p1_rdata, 32'hA5A5_A5A5);
    cyc();
    @(negedge clk);
    check("wr_adr1", bus.mem_adr, 32'h0);
    check("wr_rdata1", bus.p1_rdata, 32'h5A5A_5A5A);
    cyc();
    @(negedge clk);
    check1("wr_done", bus.p1_done, 1'b1);
    cyc();

    // Reset mid-burst after two of eight beats
    bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_adr = 32'h40; bus.p1_len = 4'd8;
    bus.p1_wdata = 32'h77;
    cyc();
    bus.p1_req = 1'b0;
    cyc();
    @(negedge clk);
    check1("rm_beat2_write", bus.mem_write, 1'b1);
    cyc();
    rst = 1'b0;
    #1;
    check1("rm_busy_drop", bus.p1_busy, 1'b0);
    check1("rm_write_drop", bus.mem_write, 1'b0);
    check1("rm_read_drop", bus.mem_read, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check1("rm_after_busy", bus.p1_busy, 1'b0);
      check1("rm_after_write", bus.mem_write, 1'b0);
      cyc();
    end
    check("rm_mem_40", mem[8'h10], 32'h77);
    check("rm_mem_44", mem[8'h11], 32'h77);
    check("rm_mem_48", mem[8'h12], 32'h0);
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_adr = 32'h100; bus.p1_len = 4'd1;
    cyc();
    bus.p1_req = 1'b0;
    @(negedge clk);
    check1("rm_fresh_rvalid", bus.p1_rvalid, 1'b1);
    check("rm_fresh_rdata", bus.p1_rdata, 32'd1);
    cyc();
    @(negedge clk);
    check1("rm_fresh_done", bus.p1_done, 1'b1);
    cyc();

    // p1_req held through p1_done: ignored in the done cycle, accepted one cycle later
    bus.p1_req = 1'b1; bus.p1_we = 1'b0; bus.p1_adr = 32'h104; bus.p1_len = 4'd1;
    cyc();
    @(negedge clk);
    check1("hd_beat", bus.p1_rvalid, 1'b1);
    cyc();
    @(negedge clk);
    check1("hd_done", bus.p1_done, 1'b1);
    check1("hd_done_not_busy", bus.p1_busy, 1'b0);
    cyc();
    @(negedge clk);
    check1("hd_idle_busy", bus.p1_busy, 1'b0);
    check1("hd_idle_done", bus.p1_done, 1'b0);
    cyc();
    bus.p1_req = 1'b0;
    @(negedge clk);
    check1("hd_reaccept_busy", bus.p1_busy, 1'b1);
    check("hd_reaccept_rdata", bus.p1_rdata, 32'd2);
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
